// File: rtl/serial_parity_checker.sv
// Bit-serial parity checker: shifts in FRAME_LEN data bits MSB-first, checks the
// trailing parity bit against a running XOR, and holds the result behind valid/ready.
module serial_parity_checker #(
  parameter int FRAME_LEN = 8,
  parameter bit ODD       = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  input  logic                 abort,
  output logic [FRAME_LEN-1:0] data_out,
  output logic                 parity_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     err_count
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]    LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [FRAME_LEN-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ovalid_q, ovalid_d;
  logic [CNT_W-1:0]     errcnt_q, errcnt_d;

  logic [FRAME_LEN:0]   shift_w;
  logic                 mismatch_w;

  // Widened concatenation keeps the shift legal even when FRAME_LEN is 1.
  assign shift_w    = {data_q, bit_in};
  assign mismatch_w = (bit_in != (acc_q ^ ODD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ovalid_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ovalid_q <= ovalid_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ovalid_d = ovalid_q;
    errcnt_d = errcnt_q;

    if (abort) begin
      // Abort discards the frame in flight but leaves data_out and the error count alone.
      state_d  = COLLECT;
      cnt_d    = '0;
      acc_d    = 1'b0;
      perr_d   = 1'b0;
      ovalid_d = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (bit_valid) begin
            data_d = shift_w[FRAME_LEN-1:0];
            acc_d  = acc_q ^ bit_in;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (bit_valid) begin
            perr_d   = mismatch_w;
            ovalid_d = 1'b1;
            cnt_d    = '0;
            acc_d    = 1'b0;
            state_d  = HOLD;
            if (mismatch_w && (errcnt_q != ERR_MAX)) begin
              errcnt_d = errcnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            ovalid_d = 1'b0;
            state_d  = COLLECT;
          end
        end
        default: begin
          state_d = COLLECT;
        end
      endcase
    end
  end

  assign bit_ready  = (state_q != HOLD);
  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign out_valid  = ovalid_q;
  assign err_count  = errcnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: one even-parity and one odd-parity instance
// sharing bit_in/abort/out_ready/rst_n, each with its own bit_valid.
module tb_serial_parity_checker;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bv_e, bv_o;
  logic       abort;
  logic       out_ready;

  logic       br_e, br_o;
  logic [7:0] data_e, data_o;
  logic       perr_e, perr_o;
  logic       ov_e, ov_o;
  logic [7:0] ec_e, ec_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

  serial_parity_checker #(.FRAME_LEN(8), .ODD(1'b0), .CNT_W(8)) u_even (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bv_e),
    .bit_ready  (br_e),
    .abort      (abort),
    .data_out   (data_e),
    .parity_err (perr_e),
    .out_valid  (ov_e),
    .out_ready  (out_ready),
    .err_count  (ec_e)
  );

  serial_parity_checker #(.FRAME_LEN(8), .ODD(1'b1), .CNT_W(8)) u_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bv_o),
    .bit_ready  (br_o),
    .abort      (abort),
    .data_out   (data_o),
    .parity_err (perr_o),
    .out_valid  (ov_o),
    .out_ready  (out_ready),
    .err_count  (ec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One transfer to the selected instance; returns 1 time unit after the edge.
  task automatic send_bit(input logic sel_odd, input logic b);
    bit_in = b;
    if (sel_odd) bv_o = 1'b1; else bv_e = 1'b1;
    @(posedge clk); #1;
    bv_e = 1'b0;
    bv_o = 1'b0;
  endtask

  task automatic send_data(input logic sel_odd, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(sel_odd, d[i]);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bv_e = 1'b0; bv_o = 1'b0; abort = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(ov_e), 32'd0);
    chk("rst_data_out", 32'(data_e), 32'h00);
    chk("rst_err_count", 32'(ec_e), 32'd0);
    chk("rst_parity_err", 32'(perr_e), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_bit_ready", 32'(br_e), 32'd1);

    // Even frame B2 with correct parity 0
    send_data(1'b0, 8'hB2);
    chk("t1_no_valid_before_parity", 32'(ov_e), 32'd0);
    send_bit(1'b0, 1'b0);
    chk("t1_out_valid", 32'(ov_e), 32'd1);
    chk("t1_data_out", 32'(data_e), 32'hB2);
    chk("t1_parity_err", 32'(perr_e), 32'd0);
    chk("t1_err_count", 32'(ec_e), 32'd0);
    chk("t1_bit_ready_hold", 32'(br_e), 32'd0);
    consume();
    chk("t1_out_valid_cleared", 32'(ov_e), 32'd0);
    chk("t1_bit_ready_back", 32'(br_e), 32'd1);

    // Same data, wrong parity
    send_data(1'b0, 8'hB2);
    send_bit(1'b0, 1'b1);
    chk("t2_parity_err", 32'(perr_e), 32'd1);
    chk("t2_err_count", 32'(ec_e), 32'd1);
    consume();

    // Error counter saturation
    for (int f = 0; f < 253; f++) begin
      send_data(1'b0, 8'hB2);
      send_bit(1'b0, 1'b1);
      consume();
    end
    chk("sat_err_count_254", 32'(ec_e), 32'hFE);
    send_data(1'b0, 8'hB2);
    send_bit(1'b0, 1'b1);
    chk("sat_err_count_255", 32'(ec_e), 32'hFF);
    consume();
    send_data(1'b0, 8'hB2);
    send_bit(1'b0, 1'b1);
    chk("sat_err_count_held", 32'(ec_e), 32'hFF);
    chk("sat_parity_err", 32'(perr_e), 32'd1);
    consume();

    // Odd parity instance
    send_data(1'b1, 8'hFF);
    send_bit(1'b1, 1'b1);
    chk("odd_ok_out_valid", 32'(ov_o), 32'd1);
    chk("odd_ok_parity_err", 32'(perr_o), 32'd0);
    chk("odd_ok_data_out", 32'(data_o), 32'hFF);
    consume();
    send_data(1'b1, 8'hFF);
    send_bit(1'b1, 1'b0);
    chk("odd_bad_parity_err", 32'(perr_o), 32'd1);
    chk("odd_bad_err_count", 32'(ec_o), 32'd1);
    consume();

    // Backpressure: bits offered while the result is held must be ignored
    send_data(1'b0, 8'h3C);
    send_bit(1'b0, 1'b0);
    chk("bp_out_valid", 32'(ov_e), 32'd1);
    out_ready = 1'b0;
    bv_e = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bit_in = c[0];
      @(posedge clk); #1;
      chk("bp_bit_ready_low", 32'(br_e), 32'd0);
      chk("bp_data_stable", 32'(data_e), 32'h3C);
      chk("bp_out_valid_held", 32'(ov_e), 32'd1);
      chk("bp_parity_err_held", 32'(perr_e), 32'd0);
    end
    bit_in = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", 32'(ov_e), 32'd0);
    chk("bp_release_no_shift", 32'(data_e), 32'h3C);
    chk("bp_release_bit_ready", 32'(br_e), 32'd1);
    @(posedge clk); #1;
    bv_e = 1'b0;
    chk("bp_next_bit_accepted", 32'(data_e), 32'h79);

    // Abort mid-frame (5 data bits in flight), then a full clean frame
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("ab_partial_data", 32'(data_e), 32'h9B);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_data_kept", 32'(data_e), 32'h9B);
    chk("ab_out_valid", 32'(ov_e), 32'd0);
    chk("ab_err_count_kept", 32'(ec_e), 32'hFF);
    send_data(1'b0, 8'h0F);
    chk("ab_no_early_result", 32'(ov_e), 32'd0);
    send_bit(1'b0, 1'b0);
    chk("ab_frame_out_valid", 32'(ov_e), 32'd1);
    chk("ab_frame_data", 32'(data_e), 32'h0F);
    chk("ab_frame_parity_err", 32'(perr_e), 32'd0);
    consume();

    // Abort coinciding with a (mismatching) parity transfer on the odd instance
    send_data(1'b1, 8'h01);
    abort = 1'b1;
    send_bit(1'b1, 1'b1);
    abort = 1'b0;
    chk("abp_out_valid", 32'(ov_o), 32'd0);
    chk("abp_err_count", 32'(ec_o), 32'd1);
    chk("abp_bit_ready", 32'(br_o), 32'd1);
    send_data(1'b1, 8'h00);
    chk("abp_next_no_early", 32'(ov_o), 32'd0);
    send_bit(1'b1, 1'b1);
    chk("abp_next_out_valid", 32'(ov_o), 32'd1);
    chk("abp_next_parity_err", 32'(perr_o), 32'd0);
    chk("abp_next_data", 32'(data_o), 32'h00);
    consume();

    // Asynchronous reset mid-frame, away from any clock edge
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data_out", 32'(data_e), 32'h00);
    chk("arst_err_count", 32'(ec_e), 32'h00);
    chk("arst_out_valid", 32'(ov_e), 32'd0);
    chk("arst_parity_err", 32'(perr_e), 32'd0);
    chk("arst_odd_err_count", 32'(ec_o), 32'h00);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_bit_ready", 32'(br_e), 32'd1);
    send_data(1'b0, 8'hA5);
    send_bit(1'b0, 1'b0);
    chk("arst_frame_out_valid", 32'(ov_e), 32'd1);
    chk("arst_frame_data", 32'(data_e), 32'hA5);
    chk("arst_frame_parity_err", 32'(perr_e), 32'd0);
    chk("arst_frame_err_count", 32'(ec_e), 32'h00);
    consume();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
